// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the registered ALU control sequencer.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ALU_OP_RTYPE = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_10    = 2'b10;
  localparam logic [1:0] ALU_OP_ADD   = 2'b11;

  localparam int CTRL_OP01_DEF = 1;
  localparam int CTRL_OP10_DEF = 4;
  localparam int CTRL_OP11_DEF = 0;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between main control and the ALU control sequencer.
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] alu_funct;
  logic               flush;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               out_valid;
  logic               mc_start;
  logic               mc_busy;
  logic               mc_abort;

  modport master (
    output in_valid, alu_op, alu_funct, flush,
    input  in_ready, alu_ctrl, out_valid, mc_start, mc_busy, mc_abort
  );

  modport slave (
    input  in_valid, alu_op, alu_funct, flush,
    output in_ready, alu_ctrl, out_valid, mc_start, mc_busy, mc_abort
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational op/funct to ALU control code map, plus multi-cycle detection.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 4,
  parameter int CTRL_W    = 4,
  parameter int CTRL_OP01 = CTRL_OP01_DEF,
  parameter int CTRL_OP10 = CTRL_OP10_DEF,
  parameter int CTRL_OP11 = CTRL_OP11_DEF
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] alu_funct,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               is_mc
);

  always_comb begin
    alu_ctrl = '0;
    is_mc    = 1'b0;
    case (alu_op)
      ALU_OP_RTYPE: begin
        alu_ctrl = CTRL_W'(alu_funct);
        // funct MSB marks the multiply/divide class
        is_mc    = alu_funct[FUNCT_W-1];
      end
      ALU_OP_SUB: alu_ctrl = CTRL_W'(CTRL_OP01);
      ALU_OP_10:  alu_ctrl = CTRL_W'(CTRL_OP10);
      ALU_OP_ADD: alu_ctrl = CTRL_W'(CTRL_OP11);
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode with multi-cycle sequencing and ready/valid back-pressure.
//   state   | meaning
//   IDLE    | ready; single-cycle ops complete here at one per cycle
//   RUN     | multi-cycle op in flight, counter running down, pipeline stalled
//   DONE    | multi-cycle result final, out_valid pulses
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 4,
  parameter int CTRL_W    = 4,
  parameter int MC_CYCLES = 32,
  parameter int CTRL_OP01 = CTRL_OP01_DEF,
  parameter int CTRL_OP10 = CTRL_OP10_DEF,
  parameter int CTRL_OP11 = CTRL_OP11_DEF
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = $clog2(MC_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LOAD = cnt_t'(MC_CYCLES - 1);

  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_is_mc;
  logic              accept;
  logic              out_valid_q, out_valid_d;
  logic              mc_start_q, mc_start_d;
  logic              mc_busy_q, mc_busy_d;
  logic              mc_abort_q, mc_abort_d;

  alu_op_decode #(
    .FUNCT_W   (FUNCT_W),
    .CTRL_W    (CTRL_W),
    .CTRL_OP01 (CTRL_OP01),
    .CTRL_OP10 (CTRL_OP10),
    .CTRL_OP11 (CTRL_OP11)
  ) u_decode (
    .alu_op    (bus.alu_op),
    .alu_funct (bus.alu_funct),
    .alu_ctrl  (dec_ctrl),
    .is_mc     (dec_is_mc)
  );

  // ready depends on state alone so no combinational path exists from in_valid
  assign bus.in_ready = (state_q == ST_IDLE);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    mc_start_d  = 1'b0;
    mc_abort_d  = 1'b0;

    if (accept) begin
      ctrl_d = dec_ctrl;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_is_mc) begin
            state_d    = ST_RUN;
            cnt_d      = CNT_LOAD;
            mc_start_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // flush overrides everything above, including a result about to be flagged
    if (bus.flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      mc_start_d  = 1'b0;
      mc_abort_d  = (state_q == ST_RUN);
    end

    mc_busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      mc_start_q  <= 1'b0;
      mc_busy_q   <= 1'b0;
      mc_abort_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      mc_start_q  <= mc_start_d;
      mc_busy_q   <= mc_busy_d;
      mc_abort_q  <= mc_abort_d;
    end
  end

  assign bus.alu_ctrl  = ctrl_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mc_start  = mc_start_q;
  assign bus.mc_busy   = mc_busy_q;
  assign bus.mc_abort  = mc_abort_q;

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered successor to the processor's ALU control decode. It maps `alu_op`/`alu_funct` to an ALU control code like the existing decode. It also recognises multi-cycle R-type functions (multiply/divide class), sequences them with a down-counter and a small FSM, and back-pressures the datapath via a ready/valid handshake. It sits between the main control unit and the ALU/multi-cycle unit.

## Interface
Parameters:
- `FUNCT_W`, 4: width of `alu_funct`; MSB = 1 marks a multi-cycle function.
- `CTRL_W`, 4: width of `alu_ctrl`; must be ≥ `FUNCT_W`.
- `MC_CYCLES`, 32: busy cycles per multi-cycle op; legal range ≥ 1.
- `CTRL_OP01`, 1: ctrl code emitted for `alu_op`=01 (branch compare / subtract).
- `CTRL_OP10`, 4: ctrl code emitted for `alu_op`=10.
- `CTRL_OP11`, 0: ctrl code emitted for `alu_op`=11 (add).

Ports:
- `clk`, in, 1: the block's single clock. Everything is sampled on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: block can accept; high only in IDLE.
- `alu_op`, in, 2: operation class from main control.
- `alu_funct`, in, `FUNCT_W`: R-type function field.
- `flush`, in, 1: synchronous abort of any request in flight.
- `alu_ctrl`, out, `CTRL_W`: registered ALU control code.
- `out_valid`, out, 1: one-cycle pulse; `alu_ctrl` result is final.
- `mc_start`, out, 1: one-cycle pulse launching the multi-cycle unit.
- `mc_busy`, out, 1: high while a multi-cycle op runs (pipeline stall).
- `mc_abort`, out, 1: one-cycle pulse when a running op is flushed.

## Operation
- An input is accepted when `in_valid & in_ready & !flush`.
- Decode of an accepted input:
  - `alu_op`=00 → `alu_funct` zero-extended to `CTRL_W`.
  - `alu_op`=01 → `CTRL_OP01`.
  - `alu_op`=10 → `CTRL_OP10`.
  - `alu_op`=11 → `CTRL_OP11`.
- An input is multi-cycle only when `alu_op`=00 and `alu_funct[FUNCT_W-1]`=1. All other inputs are single-cycle.
- FSM states and transitions:
  - IDLE → RUN on accepting a multi-cycle input. IDLE stays IDLE on accepting a single-cycle input.
  - RUN: counter loads `MC_CYCLES-1` on entry and decrements each cycle. RUN → DONE when counter = 0.
  - DONE → IDLE unconditionally after one cycle.
- `flush`:
  - In any state, `flush` forces IDLE on the next edge and kills any pending `out_valid`.
  - If the state was RUN, `flush` also produces a `mc_abort` pulse.
  - `flush` and `in_valid` in the same cycle: `flush` wins and nothing is accepted.
- `alu_ctrl` is updated only on accept. It holds its value through RUN/DONE and afterwards until the next accept.
- Reset values: state IDLE, `alu_ctrl` 0, `out_valid` 0, `mc_start` 0, `mc_busy` 0, `mc_abort` 0, counter 0. `in_ready` is 1 while `rst_n` is high after reset.
- Reset asserted mid-RUN clears everything immediately and asynchronously. No `mc_abort` is generated.

## Timing
- Single-cycle input accepted at cycle t:
  - `alu_ctrl` and `out_valid`=1 at t+1.
  - Throughput is 1 per cycle and `in_ready` stays high.
- Multi-cycle input accepted at t:
  - At t+1: `alu_ctrl`=funct, `mc_start`=1, `mc_busy`=1.
  - `mc_busy` stays high for t+1 … t+`MC_CYCLES`.
  - DONE at t+`MC_CYCLES`+1 with `out_valid`=1 and `mc_busy`=0.
  - `in_ready` is high again at t+`MC_CYCLES`+2.
- `in_ready` is combinational from state only, with no path from `in_valid`.
- All other outputs are registered.
- `MC_CYCLES`=1 case: `mc_busy` is high for one cycle, and that cycle is the RUN cycle in which the counter is already 0.
- Counter width is `$clog2(MC_CYCLES+1)`.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the `alu_op` encodings ALU_OP_RTYPE, ALU_OP_SUB, ALU_OP_10, ALU_OP_ADD;
  - the default ctrl code constants.
- One natural sub-module: `alu_op_decode`, purely combinational, mapping op/funct to ctrl code plus an `is_mc` flag. The FSM, counter and output registers live in the top.

## Test plan
- Reset, then `alu_op`=01 accepted → next cycle `alu_ctrl`=1, `out_valid`=1, `mc_busy`=0.
- Back-to-back single ops: 11, 10, 00/funct=0x2 on three consecutive cycles → `alu_ctrl` 0, 4, 2 on the following three cycles. `in_ready` stays 1 throughout.
- `MC_CYCLES`=4, input 00/funct=0xA accepted at t:
  - `mc_start` pulses at t+1.
  - `mc_busy` is high t+1..t+4, and `in_ready`=0 over the same span.
  - `out_valid` with `alu_ctrl`=0xA at t+5.
  - `in_ready`=1 at t+6.
- `flush` at t+2 of the above → `mc_abort` pulse at t+3, state IDLE, no `out_valid`, `alu_ctrl` still 0xA.
- `flush` and `in_valid` (op 01) asserted together in IDLE → no `out_valid`, `alu_ctrl` unchanged.
- `rst_n` driven low mid-RUN → all outputs 0 immediately. After release, a single op completes normally with a 1-cycle latency.
